// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit front end.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        ERR
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Stores only know B/H/W; loads additionally accept the unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_B;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
        return ((sz == SZ_H) && addr_lo[0]) || ((sz == SZ_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign/zero extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data_c = '0;
        case (i_funct3)
            F3_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data_c = {24'h0, w_byte};
            F3_H:    o_data_c = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data_c = {16'h0, w_half};
            F3_W:    o_data_c = i_word;
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// LSU front end: one load/store at a time, single-cycle memory request, ack wait with
// timeout, and exactly one registered response per accepted operation.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [XLEN-1:0]       i_wdata,
    output logic                  o_rsp_valid,
    output logic [XLEN-1:0]       o_rsp_rdata,
    output logic [1:0]            o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic [XLEN-1:0]       o_data_wr_data,
    output logic [1:0]            o_data_size,
    output logic                  o_data_we,
    output logic                  o_data_req,
    input  logic [XLEN-1:0]       i_data_rd_data,
    input  logic                  i_data_ack
);

    lsu_state_e            r_state;
    lsu_state_e            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [1:0]            r_err_code;
    logic [1:0]            w_err_nxt;
    logic                  w_hs;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic [1:0]            r_size;
    logic                  r_ready;
    logic                  r_data_req;
    logic                  r_data_we;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_err;
    logic [XLEN-1:0]       r_rsp_rdata;
    logic [XLEN-1:0]       w_load_c;

    assign w_hs = i_valid && (r_state == IDLE);

    lsu_load_align u_align (
        .i_word    (i_data_rd_data),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data_c  (w_load_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_err_code <= ERR_OK;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_code <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err_code;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (!f3_legal(i_we, i_funct3)) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = ERR_ILLEGAL;
                    end else if (is_misaligned(f3_size(i_funct3), i_addr[1:0])) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = ERR_MISALIGN;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // Ack is tested first so an ack on the final allowed cycle still succeeds.
                if (i_data_ack) begin
                    w_state_nxt = RESP;
                end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = ERR_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operation registers double as the memory-port address/data/size drivers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= SZ_B;
        end else if (w_hs) begin
            r_we     <= i_we;
            r_funct3 <= i_funct3;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_size   <= f3_size(i_funct3);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready     <= 1'b1;
            r_data_req  <= 1'b0;
            r_data_we   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= ERR_OK;
            r_rsp_rdata <= '0;
        end else begin
            r_ready     <= (w_state_nxt == IDLE);
            r_data_req  <= (w_state_nxt == REQ);
            r_data_we   <= (w_state_nxt == REQ) && i_we;
            r_rsp_valid <= (w_state_nxt == RESP) || (w_state_nxt == ERR);
            r_rsp_err   <= (w_state_nxt == ERR) ? w_err_nxt : ERR_OK;
            if (w_state_nxt == RESP) begin
                r_rsp_rdata <= r_we ? '0 : w_load_c;
            end else if (w_state_nxt == ERR) begin
                r_rsp_rdata <= '0;
            end
        end
    end

    assign o_ready        = r_ready;
    assign o_data_req     = r_data_req;
    assign o_data_we      = r_data_we;
    assign o_data_addr    = r_addr;
    assign o_data_wr_data = r_wdata;
    assign o_data_size    = r_size;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_err      = r_rsp_err;
    assign o_rsp_rdata    = r_rsp_rdata;

endmodule
